// File: rtl/reg_writeback_if.sv
// Bundle of the producer handshakes, hazard lookup and register-file write port
// shared between the writeback queue and its neighbours.
interface reg_writeback_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
);
  logic                       alu_valid;
  logic                       alu_ready;
  logic [ADDRESS_WIDTH-1:0]   alu_rd;
  logic [DATA_WIDTH-1:0]      alu_data;
  logic                       mem_valid;
  logic                       mem_ready;
  logic [ADDRESS_WIDTH-1:0]   mem_rd;
  logic [DATA_WIDTH-1:0]      mem_data;
  logic [ADDRESS_WIDTH-1:0]   rs1;
  logic [ADDRESS_WIDTH-1:0]   rs2;
  logic                       rs1_pending;
  logic                       rs2_pending;
  logic                       we3;
  logic [ADDRESS_WIDTH-1:0]   ad3;
  logic [DATA_WIDTH-1:0]      wd3;
  logic [DATA_WIDTH-1:0]      a0;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs1, rs2,
    input  alu_ready, mem_ready, rs1_pending, rs2_pending, we3, ad3, wd3, a0, count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs1, rs2,
    output alu_ready, mem_ready, rs1_pending, rs2_pending, we3, ad3, wd3, a0, count
  );
endinterface

// File: rtl/reg_writeback.sv
// In-order writeback queue: accepts ALU/load results, drains one per cycle onto
// the register-file write port, flags pending writes and mirrors x10.
module reg_writeback #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input logic           clk,
  input logic           rst,
  reg_writeback_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(10);

  logic [ADDRESS_WIDTH-1:0] r_rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0]    r_data_q [DEPTH];
  logic [PTR_W-1:0]         r_wptr;
  logic [PTR_W-1:0]         r_rptr;
  logic [CNT_W-1:0]         r_count;

  logic                     r_we_p1;
  logic [ADDRESS_WIDTH-1:0] r_ad_p1;
  logic [DATA_WIDTH-1:0]    r_wd_p1;
  logic [DATA_WIDTH-1:0]    r_a0_p1;

  logic                     w_full;
  logic                     w_empty;
  logic                     w_mem_acc;
  logic                     w_alu_acc;
  logic                     w_push;
  logic                     w_pop;
  logic [ADDRESS_WIDTH-1:0] w_push_rd;
  logic [DATA_WIDTH-1:0]    w_push_data;
  logic [DEPTH-1:0]         w_occ;
  logic                     w_rs1_hit;
  logic                     w_rs2_hit;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  assign bus.mem_ready = !w_full;
  assign bus.alu_ready = !w_full && !bus.mem_valid;

  assign w_mem_acc   = bus.mem_valid && !w_full;
  assign w_alu_acc   = bus.alu_valid && !w_full && !bus.mem_valid;
  assign w_push_rd   = w_mem_acc ? bus.mem_rd   : bus.alu_rd;
  assign w_push_data = w_mem_acc ? bus.mem_data : bus.alu_data;
  // x0 writes finish the handshake but never occupy a slot
  assign w_push      = (w_mem_acc || w_alu_acc) && (w_push_rd != '0);
  assign w_pop       = !w_empty;

  always_comb begin
    logic [PTR_W-1:0] off;
    off       = '0;
    w_occ     = '0;
    w_rs1_hit = r_we_p1 && (r_ad_p1 == bus.rs1);
    w_rs2_hit = r_we_p1 && (r_ad_p1 == bus.rs2);
    for (int i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - r_rptr;
      w_occ[i] = ({1'b0, off} < r_count);
      if (w_occ[i] && (r_rd_q[i] == bus.rs1)) w_rs1_hit = 1'b1;
      if (w_occ[i] && (r_rd_q[i] == bus.rs2)) w_rs2_hit = 1'b1;
    end
  end

  assign bus.rs1_pending = (bus.rs1 != '0) && w_rs1_hit;
  assign bus.rs2_pending = (bus.rs2 != '0) && w_rs2_hit;

  // Stage p0: queue storage, written only on an accepted non-x0 result
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_q[r_wptr]   <= w_push_rd;
      r_data_q[r_wptr] <= w_push_data;
    end
  end

  // Stage p1: pointers, occupancy and the registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_we_p1 <= 1'b0;
      r_ad_p1 <= '0;
      r_wd_p1 <= '0;
      r_a0_p1 <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_we_p1 <= w_pop;
      if (w_pop) begin
        r_rptr  <= r_rptr + PTR_W'(1);
        r_ad_p1 <= r_rd_q[r_rptr];
        r_wd_p1 <= r_data_q[r_rptr];
        if (r_rd_q[r_rptr] == A0_IDX) r_a0_p1 <= r_data_q[r_rptr];
      end
    end
  end

  assign bus.we3   = r_we_p1;
  assign bus.ad3   = r_ad_p1;
  assign bus.wd3   = r_wd_p1;
  assign bus.a0    = r_a0_p1;
  assign bus.count = r_count;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed and randomised bench for reg_writeback with a queue scoreboard of
// expected register-file writes.
module tb_reg_writeback;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_writeback_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  reg_writeback #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  entry_t        sb[$];
  int            m_cnt   = 0;
  logic          last_we = 1'b0;
  logic [AW-1:0] m_ad    = '0;
  logic [DW-1:0] m_wd    = '0;
  logic [DW-1:0] m_a0    = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic pend_model(input logic [AW-1:0] rs);
    if (rs == '0) return 1'b0;
    if (last_we && (m_ad == rs)) return 1'b1;
    foreach (sb[i]) if (sb[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
  endtask

  // One clock of the scoreboard model around whatever inputs are currently driven
  task automatic step();
    entry_t e;
    logic   mr, ar, acc, pop;
    e = '{rd: '0, data: '0};
    #1;
    mr = (m_cnt != DEPTH);
    ar = mr && !bus.mem_valid;
    chk("mem_ready",   32'(bus.mem_ready),   32'(mr));
    chk("alu_ready",   32'(bus.alu_ready),   32'(ar));
    chk("rs1_pending", 32'(bus.rs1_pending), 32'(pend_model(bus.rs1)));
    chk("rs2_pending", 32'(bus.rs2_pending), 32'(pend_model(bus.rs2)));
    acc = 1'b0;
    if (bus.mem_valid && mr) begin
      e.rd = bus.mem_rd; e.data = bus.mem_data; acc = 1'b1;
    end else if (bus.alu_valid && ar) begin
      e.rd = bus.alu_rd; e.data = bus.alu_data; acc = 1'b1;
    end
    pop = (m_cnt != 0);
    if (acc && (e.rd != '0)) begin
      sb.push_back(e);
      m_cnt++;
    end
    if (pop) m_cnt--;
    @(posedge clk);
    #1;
    chk("we3", 32'(bus.we3), 32'(pop));
    if (pop) begin
      e    = sb.pop_front();
      m_ad = e.rd;
      m_wd = e.data;
      if (e.rd == AW'(10)) m_a0 = e.data;
    end
    chk("ad3",   32'(bus.ad3),   32'(m_ad));
    chk("wd3",   bus.wd3,        m_wd);
    chk("a0",    bus.a0,         m_a0);
    chk("count", 32'(bus.count), 32'(m_cnt));
    last_we = pop;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 32'd0);
    chk({tag, "_we3"},   32'(bus.we3),   32'd0);
    chk({tag, "_ad3"},   32'(bus.ad3),   32'd0);
    chk({tag, "_wd3"},   bus.wd3,        32'd0);
    chk({tag, "_a0"},    bus.a0,         32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    bus.rs1 = '0;
    bus.rs2 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    chk("rst_mem_ready", 32'(bus.mem_ready),   32'd1);
    chk("rst_alu_ready", 32'(bus.alu_ready),   32'd1);
    chk("rst_pend1",     32'(bus.rs1_pending), 32'd0);
    rst = 1'b0;

    // Single write with hazard tracking on rs1
    bus.rs1 = AW'(5); bus.rs2 = AW'(6);
    bus.alu_valid = 1'b1; bus.alu_rd = AW'(5); bus.alu_data = 32'h1234;
    step();
    idle_inputs();
    repeat (3) step();

    // Arbitration: load wins, ALU result follows on the next cycle
    bus.rs1 = AW'(3); bus.rs2 = AW'(4);
    bus.alu_valid = 1'b1; bus.alu_rd = AW'(3); bus.alu_data = 32'hA;
    bus.mem_valid = 1'b1; bus.mem_rd = AW'(4); bus.mem_data = 32'hB;
    step();
    bus.mem_valid = 1'b0;
    step();
    idle_inputs();
    repeat (3) step();

    // Back-to-back loads with the ALU held off
    for (int i = 0; i < DEPTH + 2; i++) begin
      bus.mem_valid = 1'b1; bus.mem_rd = AW'(i + 1); bus.mem_data = 32'h100 + 32'(i);
      bus.alu_valid = 1'b1; bus.alu_rd = AW'(20);     bus.alu_data = 32'hDEAD;
      bus.rs1 = AW'(i + 1); bus.rs2 = AW'(i);
      step();
    end
    idle_inputs();
    repeat (3) step();

    // x0 filter, then an a0 update
    bus.rs1 = '0; bus.rs2 = AW'(10);
    bus.alu_valid = 1'b1; bus.alu_rd = '0; bus.alu_data = 32'hFFFF;
    step();
    idle_inputs();
    step();
    bus.alu_valid = 1'b1; bus.alu_rd = AW'(10); bus.alu_data = 32'hCAFE;
    step();
    idle_inputs();
    repeat (3) step();

    // Reset while work is in flight
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = AW'(7 + i); bus.alu_data = 32'h700 + 32'(i);
      step();
    end
    bus.mem_valid = 1'b1; bus.mem_rd = AW'(10); bus.mem_data = 32'h5555;
    step();
    idle_inputs();
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    sb.delete();
    m_cnt = 0; last_we = 1'b0; m_ad = '0; m_wd = '0; m_a0 = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    bus.alu_valid = 1'b1; bus.alu_rd = AW'(12); bus.alu_data = 32'h00C0FFEE;
    bus.rs1 = AW'(12);
    step();
    idle_inputs();
    repeat (3) step();

    // Randomised mix of both producers and hazard lookups
    for (int i = 0; i < 60; i++) begin
      bus.alu_valid = 1'($urandom_range(0, 1));
      bus.alu_rd    = AW'($urandom_range(0, 15));
      bus.alu_data  = $urandom;
      bus.mem_valid = 1'($urandom_range(0, 1));
      bus.mem_rd    = AW'($urandom_range(0, 15));
      bus.mem_data  = $urandom;
      bus.rs1       = AW'($urandom_range(0, 15));
      bus.rs2       = AW'($urandom_range(0, 15));
      step();
    end
    idle_inputs();
    repeat (3) step();
    chk("drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side companion to the register-file read block. It accepts completed results from the ALU path and the memory-load path over valid/ready handshakes, buffers them in a small in-order queue, and drains one result per cycle onto the register file's single write port (`we3`/`ad3`/`wd3`). It also reports pending writes so the issue logic can stall on read-after-write hazards, and keeps a registered mirror of `a0` (x10) for the top level.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 5: register index width.
- `DATA_WIDTH`, 32: register data width.
- `DEPTH`, 4: queue entries. Must be a power of two, at least 2.

Ports:
- `clk`, in, 1: single clock. All state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `alu_valid`, in, 1: ALU result offered.
- `alu_ready`, out, 1: ALU result accepted this cycle.
- `alu_rd`, in, `ADDRESS_WIDTH`: ALU destination register.
- `alu_data`, in, `DATA_WIDTH`: ALU result.
- `mem_valid`, in, 1: load result offered.
- `mem_ready`, out, 1: load result accepted this cycle.
- `mem_rd`, in, `ADDRESS_WIDTH`: load destination register.
- `mem_data`, in, `DATA_WIDTH`: load result.
- `rs1`, in, `ADDRESS_WIDTH`: first source index to check for a pending write.
- `rs2`, in, `ADDRESS_WIDTH`: second source index to check for a pending write.
- `rs1_pending`, out, 1: a write to `rs1` has not yet reached the register file.
- `rs2_pending`, out, 1: a write to `rs2` has not yet reached the register file.
- `we3`, out, 1: register-file write enable, registered.
- `ad3`, out, `ADDRESS_WIDTH`: register-file write address, registered.
- `wd3`, out, `DATA_WIDTH`: register-file write data, registered.
- `a0`, out, `DATA_WIDTH`: mirror of x10, registered.
- `count`, out, $clog2(`DEPTH`)+1: queue occupancy.

## Operation
- **Queue:** circular FIFO of {rd, data} with read/write pointers and an occupancy counter. full = (`count` == `DEPTH`); empty = (`count` == 0). Pointers wrap modulo `DEPTH`.
- **Ready, combinational:**
  - `mem_ready` = !full.
  - `alu_ready` = !full && !`mem_valid`.
- **Arbitration:** memory has fixed priority. At most one enqueue per cycle. The handshake completes on a rising edge where valid && ready.
- **x0 filter:** an accepted transfer with rd == 0 completes its handshake but is not enqueued, and `count` is unchanged.
- **Drain, every edge:**
  - If not empty: pop the head and register it: `we3`<=1, `ad3`<=head.rd, `wd3`<=head.data.
  - If empty: `we3`<=0. `ad3` and `wd3` hold their values.
- **Simultaneous push and pop:** both happen on the same edge and `count` is unchanged. Full is evaluated before the pop, so a full queue refuses input even on a draining cycle.
- **a0 mirror:** on the edge that loads `we3`=1 with `ad3`=10, `a0` also loads the same data. Otherwise `a0` holds.
- **Pending (combinational):** `rsN_pending` = (`rsN` != 0) && (`rsN` matches rd of any occupied queue entry, or (`we3` && `ad3` == `rsN`)). The `we3` term covers the cycle before the register file captures the write.
- **Ordering:** writes reach the register file in acceptance order. A later write to the same rd overwrites an earlier one.

## Timing
- Result accepted at edge N → `we3`/`ad3`/`wd3` valid after edge N+1 if the queue was empty → register file captures at edge N+2. Each occupied entry ahead adds one cycle.
- Sustained throughput: one result per cycle. A second source is held off by its ready signal.
- Values after reset:
  - `we3`=0, `ad3`=0, `wd3`=0, `a0`=0, `count`=0.
  - Both pointers 0.
  - `alu_ready`=`mem_ready`=1, pending outputs 0.
- Reset asserted mid-operation: all queued entries are discarded immediately, with no partial write. Outputs take their reset values asynchronously.
- Ready outputs depend combinationally on `mem_valid` and `count` only, never on `alu_valid`.
- Pending outputs depend combinationally on `rs1`/`rs2`, queue contents and `we3`/`ad3`.

## Test plan
- **Single write:** reset, then `alu_valid`=1, `alu_rd`=5, `alu_data`=0x1234 for one cycle → one cycle later `we3`=1, `ad3`=5, `wd3`=0x1234. `we3`=0 on the following cycle. `rs1`=5 reads pending=1 from acceptance until `we3` drops.
- **Arbitration:** `alu_valid` and `mem_valid` both high (alu rd=3 data=0xA, mem rd=4 data=0xB) → `mem_ready`=1 and `alu_ready`=0. Next cycle `alu_ready`=1 and the ALU result is accepted. Writes appear in order: rd 4 then rd 3.
- **Full:** hold `DEPTH`+2 back-to-back load results to distinct rd → `count` never exceeds 4 and `mem_ready` drops only while full. All results appear on `wd3` in order with none lost or duplicated.
- **x0 filter and a0:** write rd=0 data=0xFFFF → handshake completes, `count` stays 0, `we3` stays 0, and `rs1`=0 pending=0. Then write rd=10 data=0xCAFE → `a0`=0xCAFE on the same edge `we3` rises.
- **Reset mid-operation:** enqueue 3 entries, assert `rst` for one cycle → `count`=0, `we3`=0, `a0`=0 immediately. After release no stale write appears and the next accepted result is written normally.
